axi4_sram_slave: RTL and testbench
==================================

Name: axi4_sram_slave

Overview:
- AXI4 slave memory model that sits at the other end of the master_axi_4 interfaces; it answers the D-cache/I-cache refill and writeback bursts.
- Owns a word-addressed register-array memory with independent read and write channel FSMs.
- Supports FIXED/INCR/WRAP bursts, byte strobes and ID echo.
- Used in the simulation top in place of DPI memory, and as a synthesizable on-chip RAM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; 8-byte words.
- ID_W, 4, transaction ID width.
- MEM_DEPTH, 4096, number of 64-bit words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, idle cycles between AR handshake and first R beat (0..15).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  input  ID_W/ADDR_W/8/3/2  write address.
- S_AXI_AWVALID input 1; S_AXI_AWREADY output 1  AW handshake.
- S_AXI_WDATA/WSTRB/WLAST  input  DATA_W/8/1  write data.
- S_AXI_WVALID input 1; S_AXI_WREADY output 1  W handshake.
- S_AXI_BID/BRESP  output  ID_W/2  write response.
- S_AXI_BVALID output 1; S_AXI_BREADY input 1  B handshake.
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  input  ID_W/ADDR_W/8/3/2  read address.
- S_AXI_ARVALID input 1; S_AXI_ARREADY output 1  AR handshake.
- S_AXI_RID/RDATA/RRESP/RLAST  output  ID_W/DATA_W/2/1  read data.
- S_AXI_RVALID output 1; S_AXI_RREADY input 1  R handshake.

Behaviour:
- Reset values: AWREADY=1, ARREADY=1. All other outputs 0.
- Reset mid-burst: both FSMs abort to IDLE and the in-flight burst is dropped. Memory contents are never reset.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On AW handshake, latch id/addr/len/size/burst, clear beat counter and error flag, go to W_DATA.
  - W_DATA: WREADY=1, AWREADY=0. Each W handshake writes the strobed bytes to mem[idx] and advances the address.
  - Leave W_DATA when beat count == len. WLAST does not terminate the burst; a WLAST mismatch (early or missing) sets the error flag.
  - W_RESP: BVALID=1, BID=latched id, BRESP = SLVERR(2'b10) if error else OKAY. BVALID is held until BREADY, then go to W_IDLE with AWREADY=1 next cycle.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake (cycle T), latch fields. Go to R_WAIT if RD_LAT>0, else R_DATA.
  - First RVALID is asserted in cycle T+1+RD_LAT.
  - R_DATA: RVALID=1, RDATA=mem[idx] (full aligned word; the master shifts narrow data). RLAST=1 on beat len.
  - RDATA/RID/RRESP/RLAST are stable while RVALID && !RREADY.
  - On handshake, advance. After the last beat, return to R_IDLE.
- Index: idx = ((addr - BASE_ADDR) >> 3) mod MEM_DEPTH.
- Next address:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: container = (len+1)<<size bytes, aligned down. The address wraps to the container base when the increment crosses the container top.
  - Reserved burst 2'b11 is treated as INCR with SLVERR.
- Size > 3: SLVERR on every R beat or on the B response. Writes still apply the strobes.
- Simultaneous read and write of the same word in one cycle: R sees the old value; the write commits at the clock edge.
- Read and write channels run fully concurrently. There is no ordering between them.

Optional Feature:
- Macro: AXI_SRAM_ADDR_CHECK_EN.
- Defined: any beat address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*8) returns DECERR(2'b11).
  - Writes to such beats are suppressed.
  - Reads of such beats return RDATA=0.
  - DECERR has priority over SLVERR in BRESP.
- Undefined: no range check. The address wraps modulo MEM_DEPTH, and responses are OKAY except for the SLVERR cases above.

Decomposition:
- Shared package axi_pkg:
  - BURST_FIXED/INCR/WRAP encodings.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - Write and read FSM state typedefs.
- One sub-module: axi_burst_addr_gen, the combinational next-address computation over addr/len/size/burst. It is instantiated once per channel.

Test Plan:
- Single write/read: AW addr 0x8000_0010 len0 size3 INCR, WDATA 0x1122334455667788, WSTRB 0xFF; then AR same address. Required: BRESP=0, and RDATA=0x1122334455667788 at T+2 with RD_LAT=1.
- Strobe merge: write 0xFF..FF with strobe 0xFF, then data 0 with WSTRB 0x0F at the same address. Required: read returns 0xFFFFFFFF00000000.
- WRAP burst: read at 0x8000_0030, len3, size3, WRAP, with words 0x20..0x38 preloaded to values 0..3. Required: beats return words 2,3,0,1, with RLAST only on the 4th beat.
- Backpressure: 8-beat INCR read with RREADY toggling 1,0,0,1. Required: RDATA and RLAST are stable through the stalls, and exactly 8 handshakes occur.
- Protocol errors:
  - 4-beat write with WLAST asserted on beat 2: all 4 beats are consumed and BRESP=SLVERR.
  - ARSIZE=4: SLVERR on every R beat.
- Reset mid-burst plus concurrency:
  - rst low during beat 2 of a read: after release, RVALID=0, ARREADY=1, and memory is unchanged.
  - Concurrent AW and AR to the same word: the read returns the pre-write value.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, response helpers and FSM state types for the SRAM slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  // Decode errors outrank slave errors.
  function automatic logic [1:0] beat_resp(input logic dec_err, input logic slv_err);
    logic [1:0] resp;
    if (dec_err) begin
      resp = RESP_DECERR;
    end else if (slv_err) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

  // Reserved burst type or a beat wider than the 8-byte bus.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_RSVD) || (size > 3'd3);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] incr_s;
  logic [ADDR_W-1:0] incr_addr_s;
  logic [ADDR_W-1:0] wrap_mask_s;

  always_comb begin
    incr_s      = ONE << size_i;
    incr_addr_s = addr_i + incr_s;
    // The wrap container is (len+1) beats, a power of two for legal WRAP bursts.
    wrap_mask_s = ((ADDR_W'(len_i) + ONE) << size_i) - ONE;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
      default:     next_addr_o = incr_addr_s;
    endcase
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a word-addressed register array, independent read/write FSMs.
// Optional address range checking (DECERR) is enabled with `define AXI_SRAM_ADDR_CHECK_EN.
module axi4_sram_slave
  import axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     S_AXI_AWID,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [7:0]          S_AXI_AWLEN,
  input  logic [2:0]          S_AXI_AWSIZE,
  input  logic [1:0]          S_AXI_AWBURST,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [ID_W-1:0]     S_AXI_BID,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ID_W-1:0]     S_AXI_ARID,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [7:0]          S_AXI_ARLEN,
  input  logic [2:0]          S_AXI_ARSIZE,
  input  logic [1:0]          S_AXI_ARBURST,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [ID_W-1:0]     S_AXI_RID,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RLAST,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'((off >> 3'd3) % ADDR_W'(MEM_DEPTH));
  endfunction

  // Write channel state
  w_state_e          w_state_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [7:0]        w_len_q;
  logic [2:0]        w_size_q;
  logic [1:0]        w_burst_q;
  logic [7:0]        w_cnt_q;
  logic              w_err_q;
  logic              w_dec_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] w_addr_d;
  logic              w_in_range_s;
  logic              w_last_s;
  logic              w_wlast_err_s;
  logic              w_wr_en_s;

  // Read channel state
  r_state_e          r_state_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [7:0]        r_len_q;
  logic [2:0]        r_size_q;
  logic [1:0]        r_burst_q;
  logic [7:0]        r_cnt_q;
  logic [3:0]        r_wait_q;
  logic              r_err_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] r_addr_d;
  logic [ADDR_W-1:0] r_fetch_addr_s;
  logic [DATA_W-1:0] r_fetch_data_s;
  logic              r_slv_s;
  logic              r_in_range_s;

`ifdef AXI_SRAM_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_DEPTH) << 3'd3;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[ADDR_W] && (off < MEM_BYTES);
  endfunction

  assign w_in_range_s = addr_in_range(w_addr_q);
  assign r_in_range_s = addr_in_range(r_fetch_addr_s);
`else
  assign w_in_range_s = 1'b1;
  assign r_in_range_s = 1'b1;
`endif

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_waddr_gen (
    .addr_i      (w_addr_q),
    .len_i       (w_len_q),
    .size_i      (w_size_q),
    .burst_i     (w_burst_q),
    .next_addr_o (w_addr_d)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_raddr_gen (
    .addr_i      (r_addr_q),
    .len_i       (r_len_q),
    .size_i      (r_size_q),
    .burst_i     (r_burst_q),
    .next_addr_o (r_addr_d)
  );

  // Beat-level write decode; WLAST only flags an error, the beat counter ends the burst.
  always_comb begin
    w_last_s      = (w_cnt_q == w_len_q);
    w_wlast_err_s = (S_AXI_WLAST != w_last_s);
    w_wr_en_s     = (w_state_q == W_DATA) && S_AXI_WVALID && w_in_range_s;
  end

  // Write-channel FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= {ADDR_W{1'b0}};
      w_len_q   <= 8'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
      w_dec_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= {ID_W{1'b0}};
      bresp_q   <= 2'd0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (S_AXI_AWVALID && awready_q) begin
            w_addr_q  <= S_AXI_AWADDR;
            w_len_q   <= S_AXI_AWLEN;
            w_size_q  <= S_AXI_AWSIZE;
            w_burst_q <= S_AXI_AWBURST;
            bid_q     <= S_AXI_AWID;
            w_cnt_q   <= 8'd0;
            w_err_q   <= burst_err(S_AXI_AWBURST, S_AXI_AWSIZE);
            w_dec_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID && wready_q) begin
            w_addr_q <= w_addr_d;
            w_cnt_q  <= w_cnt_q + 8'd1;
            if (w_last_s) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= beat_resp(w_dec_q | ~w_in_range_s, w_err_q | w_wlast_err_s);
              w_state_q <= W_RESP;
            end else begin
              w_err_q <= w_err_q | w_wlast_err_s;
              w_dec_q <= w_dec_q | ~w_in_range_s;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          bvalid_q  <= 1'b0;
          wready_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Byte-strobed memory write; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) begin
          mem_q[word_idx(w_addr_q)][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
        end
      end
    end
  end

  // Address of the beat being loaded into the R output register this cycle.
  always_comb begin
    case (r_state_q)
      R_IDLE:  r_fetch_addr_s = S_AXI_ARADDR;
      R_DATA:  r_fetch_addr_s = r_addr_d;
      default: r_fetch_addr_s = r_addr_q;
    endcase
    if (r_state_q == R_IDLE) begin
      r_slv_s = burst_err(S_AXI_ARBURST, S_AXI_ARSIZE);
    end else begin
      r_slv_s = r_err_q;
    end
    if (r_in_range_s) begin
      r_fetch_data_s = mem_q[word_idx(r_fetch_addr_s)];
    end else begin
      r_fetch_data_s = {DATA_W{1'b0}};
    end
  end

  // Read-channel FSM; R outputs only change on entry to R_DATA or on a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= {ADDR_W{1'b0}};
      r_len_q   <= 8'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_cnt_q   <= 8'd0;
      r_wait_q  <= 4'd0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= {ID_W{1'b0}};
      rresp_q   <= 2'd0;
      rdata_q   <= {DATA_W{1'b0}};
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            r_addr_q  <= S_AXI_ARADDR;
            r_len_q   <= S_AXI_ARLEN;
            r_size_q  <= S_AXI_ARSIZE;
            r_burst_q <= S_AXI_ARBURST;
            r_cnt_q   <= 8'd0;
            r_err_q   <= r_slv_s;
            rid_q     <= S_AXI_ARID;
            arready_q <= 1'b0;
            if (RD_LAT == 0) begin
              rvalid_q  <= 1'b1;
              rdata_q   <= r_fetch_data_s;
              rresp_q   <= beat_resp(~r_in_range_s, r_slv_s);
              rlast_q   <= (S_AXI_ARLEN == 8'd0);
              r_state_q <= R_DATA;
            end else begin
              r_wait_q  <= 4'(RD_LAT - 1);
              r_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_wait_q == 4'd0) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= r_fetch_data_s;
            rresp_q   <= beat_resp(~r_in_range_s, r_slv_s);
            rlast_q   <= (r_len_q == 8'd0);
            r_state_q <= R_DATA;
          end else begin
            r_wait_q <= r_wait_q - 4'd1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (r_cnt_q == r_len_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_addr_q <= r_addr_d;
              r_cnt_q  <= r_cnt_q + 8'd1;
              rdata_q  <= r_fetch_data_s;
              rresp_q  <= beat_resp(~r_in_range_s, r_slv_s);
              rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: begin
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
          arready_q <= 1'b1;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: vector table of single-beat write/read pairs
// plus hand-written WRAP, backpressure, protocol-error, reset and concurrency sequences.
module tb_axi4_sram_slave;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  awid = 4'd0;
  logic [31:0] awaddr = 32'd0;
  logic [7:0]  awlen = 8'd0;
  logic [2:0]  awsize = 3'd0;
  logic [1:0]  awburst = 2'd0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = 64'd0;
  logic [7:0]  wstrb = 8'd0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = 4'd0;
  logic [31:0] araddr = 32'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [63:0] rd_data_a [16];
  logic        rd_last_a [16];
  logic [1:0]  rd_resp_a [16];
  logic [3:0]  rd_id;
  int          rd_beats;
  int          rd_lat;

  typedef struct {
    logic [31:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  wburst;
    logic [31:0] raddr;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  axi4_sram_slave #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid_o), .S_AXI_BRESP(bresp_o), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid_o), .S_AXI_RDATA(rdata_o), .S_AXI_RRESP(rresp_o), .S_AXI_RLAST(rlast_o),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int last_beat,
                           input logic [7:0] strb, input logic [63:0] base,
                           output logic [1:0] resp, output logic [3:0] bid, output int beats);
    int guard;
    beats = 0;
    resp  = 2'b00;
    bid   = 4'd0;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(negedge clk); guard++; end
    chk("aw_handshake_in_time", 64'(guard < 50), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = base + 64'(i);
      wstrb  = strb;
      wlast  = (last_beat < 0) ? (i == int'(len)) : (i == last_beat);
      guard  = 0;
      while (!wready && guard < 50) begin @(negedge clk); guard++; end
      if (guard < 50) beats++;
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    guard  = 0;
    while (!bvalid && guard < 50) begin @(negedge clk); guard++; end
    chk("b_valid_in_time", 64'(guard < 50), 64'd1);
    resp = bresp_o;
    bid  = bid_o;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [3:0] pat);
    int guard;
    int k;
    logic stall;
    logic [63:0] pdata;
    logic plast;
    rd_beats = 0;
    rd_lat   = 0;
    stall    = 1'b0;
    pdata    = 64'd0;
    plast    = 1'b0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(negedge clk); guard++; end
    chk("ar_handshake_in_time", 64'(guard < 50), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    guard = 0;
    while (!rvalid && guard < 50) begin @(negedge clk); rd_lat++; guard++; end
    k = 0;
    while (rd_beats <= int'(len) && k < 200) begin
      if (stall) begin
        chk("r_stall_valid", 64'(rvalid), 64'd1);
        chk("r_stall_data", rdata_o, pdata);
        chk("r_stall_last", 64'(rlast_o), 64'(plast));
      end
      rready = pat[k % 4];
      if (rvalid && rready && rd_beats < 16) begin
        rd_data_a[rd_beats] = rdata_o;
        rd_last_a[rd_beats] = rlast_o;
        rd_resp_a[rd_beats] = rresp_o;
        rd_id = rid_o;
        rd_beats++;
      end
      stall = rvalid && !rready;
      pdata = rdata_o;
      plast = rlast_o;
      @(negedge clk);
      k++;
    end
    rready = 1'b0;
    chk("r_burst_in_time", 64'(k < 200), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bresp;
    logic [3:0] bid;
    int beats;

    vecs[0] = '{32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2'b01, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00};
    vecs[1] = '{32'h8000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b01, 32'h8000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00};
    vecs[2] = '{32'h8000_0040, 64'h0000_0000_0000_0000, 8'h0F, 2'b01, 32'h8000_0040, 64'hFFFF_FFFF_0000_0000, 2'b00};
    vecs[3] = '{32'h8000_0040, 64'h0123_4567_89AB_CDEF, 8'h81, 2'b00, 32'h8000_0040, 64'h01FF_FFFF_0000_00EF, 2'b00};
`ifdef AXI_SRAM_ADDR_CHECK_EN
    vecs[4] = '{32'h8000_8010, 64'hDEAD_BEEF_0000_1111, 8'hFF, 2'b01, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b11};
`else
    vecs[4] = '{32'h8000_8010, 64'hDEAD_BEEF_0000_1111, 8'hFF, 2'b01, 32'h8000_0010, 64'hDEAD_BEEF_0000_1111, 2'b00};
`endif
    vecs[5] = '{32'h8000_0060, 64'h5555_AAAA_5555_AAAA, 8'hFF, 2'b11, 32'h8000_0060, 64'h5555_AAAA_5555_AAAA, 2'b10};

    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      axi_write(vecs[i].waddr, 8'd0, 3'd3, vecs[i].wburst, 4'(i), -1, vecs[i].strb, vecs[i].wdata,
                bresp, bid, beats);
      chk($sformatf("vec%0d_bresp", i), 64'(bresp), 64'(vecs[i].exp_bresp));
      chk($sformatf("vec%0d_bid", i), 64'(bid), 64'(i));
      chk($sformatf("vec%0d_wbeats", i), 64'(beats), 64'd1);
      axi_read(vecs[i].raddr, 8'd0, 3'd3, 2'b01, 4'(i + 8), 4'hF);
      chk($sformatf("vec%0d_rbeats", i), 64'(rd_beats), 64'd1);
      chk($sformatf("vec%0d_rlat", i), 64'(rd_lat), 64'(RD_LAT));
      chk($sformatf("vec%0d_rdata", i), rd_data_a[0], vecs[i].exp_rdata);
      chk($sformatf("vec%0d_rresp", i), 64'(rd_resp_a[0]), 64'd0);
      chk($sformatf("vec%0d_rlast", i), 64'(rd_last_a[0]), 64'd1);
      chk($sformatf("vec%0d_rid", i), 64'(rd_id), 64'(i + 8));
    end

    // WRAP read over words 0x20..0x38 holding 0..3
    axi_write(32'h8000_0020, 8'd3, 3'd3, 2'b01, 4'd1, -1, 8'hFF, 64'd0, bresp, bid, beats);
    chk("wrap_pre_bresp", 64'(bresp), 64'd0);
    axi_read(32'h8000_0030, 8'd3, 3'd3, 2'b10, 4'd2, 4'hF);
    chk("wrap_beats", 64'(rd_beats), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_data%0d", i), rd_data_a[i], 64'((i + 2) % 4));
      chk($sformatf("wrap_last%0d", i), 64'(rd_last_a[i]), 64'(i == 3));
    end

    // FIXED burst: both beats hit the same word, the second one wins
    axi_write(32'h8000_0500, 8'd1, 3'd3, 2'b00, 4'd3, -1, 8'hFF, 64'h50, bresp, bid, beats);
    axi_read(32'h8000_0500, 8'd0, 3'd3, 2'b01, 4'd3, 4'hF);
    chk("fixed_data", rd_data_a[0], 64'h51);

    // 8-beat INCR read under RREADY 1,0,0,1 backpressure
    axi_write(32'h8000_0300, 8'd7, 3'd3, 2'b01, 4'd9, -1, 8'hFF, 64'hC0DE_0000_0000_0000, bresp, bid, beats);
    chk("bp_pre_beats", 64'(beats), 64'd8);
    axi_read(32'h8000_0300, 8'd7, 3'd3, 2'b01, 4'd10, 4'b1001);
    chk("bp_beats", 64'(rd_beats), 64'd8);
    chk("bp_rid", 64'(rd_id), 64'd10);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_data%0d", i), rd_data_a[i], 64'hC0DE_0000_0000_0000 + 64'(i));
      chk($sformatf("bp_last%0d", i), 64'(rd_last_a[i]), 64'(i == 7));
    end

    // Early WLAST on beat 2 of 4
    axi_write(32'h8000_0400, 8'd3, 3'd3, 2'b01, 4'd6, 1, 8'hFF, 64'h4000, bresp, bid, beats);
    chk("wlast_beats", 64'(beats), 64'd4);
    chk("wlast_bresp", 64'(bresp), 64'd2);
    chk("wlast_bid", 64'(bid), 64'd6);

    // ARSIZE=4: 16-byte stride, SLVERR on every beat
    axi_read(32'h8000_0400, 8'd1, 3'd4, 2'b01, 4'd7, 4'hF);
    chk("size4_beats", 64'(rd_beats), 64'd2);
    chk("size4_resp0", 64'(rd_resp_a[0]), 64'd2);
    chk("size4_resp1", 64'(rd_resp_a[1]), 64'd2);
    chk("size4_data0", rd_data_a[0], 64'h4000);
    chk("size4_data1", rd_data_a[1], 64'h4002);
    chk("size4_last1", 64'(rd_last_a[1]), 64'd1);

    // Reset during beat 2 of a 4-beat read
    axi_write(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'd5, -1, 8'hFF, 64'h7000, bresp, bid, beats);
    @(negedge clk);
    arid = 4'd5; araddr = 32'h8000_0100; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    chk("rstmid_arready", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    chk("rstmid_first_valid", 64'(rvalid), 64'd1);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rstmid_beat2", rdata_o, 64'h7001);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_in_rvalid", 64'(rvalid), 64'd0);
    chk("rstmid_in_arready", 64'(arready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_out_rvalid", 64'(rvalid), 64'd0);
    chk("rstmid_out_arready", 64'(arready), 64'd1);
    chk("rstmid_out_awready", 64'(awready), 64'd1);
    axi_read(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'd5, 4'hF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstmid_mem%0d", i), rd_data_a[i], 64'h7000 + 64'(i));
    end

    // Concurrent AW and AR to the same word: read sees the old value
    axi_write(32'h8000_0200, 8'd0, 3'd3, 2'b01, 4'd2, -1, 8'hFF, 64'h0DD0_0DD0_0DD0_0DD0, bresp, bid, beats);
    @(negedge clk);
    awid = 4'd3; awaddr = 32'h8000_0200; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd4; araddr = 32'h8000_0200; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    chk("conc_awready", 64'(awready), 64'd1);
    chk("conc_arready", 64'(arready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    arvalid = 1'b0;
    chk("conc_wready", 64'(wready), 64'd1);
    wvalid = 1'b1; wdata = 64'h0A0B_0C0D_1A1B_1C1D; wstrb = 8'hFF; wlast = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("conc_rvalid", 64'(rvalid), 64'd1);
    chk("conc_rdata_old", rdata_o, 64'h0DD0_0DD0_0DD0_0DD0);
    chk("conc_bvalid", 64'(bvalid), 64'd1);
    chk("conc_bresp", 64'(bresp_o), 64'd0);
    bready = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rready = 1'b0;
    chk("conc_rvalid_done", 64'(rvalid), 64'd0);
    chk("conc_bvalid_done", 64'(bvalid), 64'd0);
    axi_read(32'h8000_0200, 8'd0, 3'd3, 2'b01, 4'd4, 4'hF);
    chk("conc_rdata_new", rd_data_a[0], 64'h0A0B_0C0D_1A1B_1C1D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
